// File: rtl/xsm_frame_packer.sv
// Consumer end of the xsm capture stream: assembles ch0..ch7 samples into timestamped
// frames, double-buffers them and streams each frame out as six 32-bit words.
module xsm_frame_packer #(
  parameter int          SAMPLE_WIDTH = 16,
  parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic [2:0]              s_chan,
  input  logic [47:0]             s_time,
  output logic [31:0]             m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             seq_err_cnt,
  output logic                    overflow
);

  typedef enum logic {AS_WAIT0, AS_COLLECT} as_st_t;
  typedef enum logic [2:0] {
    EM_W0 = 3'd0, EM_W1 = 3'd1, EM_W2 = 3'd2, EM_W3 = 3'd3,
    EM_W4 = 3'd4, EM_W5 = 3'd5, EM_IDLE = 3'd7
  } em_st_t;
  typedef logic [7:0][15:0] smp_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] frame_word(input logic [2:0] idx, input logic [47:0] ts,
                                             input smp_t smp);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {SYNC_WORD, ts[47:32]};
      3'd1:    w = ts[31:0];
      3'd2:    w = {smp[1], smp[0]};
      3'd3:    w = {smp[3], smp[2]};
      3'd4:    w = {smp[5], smp[4]};
      default: w = {smp[7], smp[6]};
    endcase
    return w;
  endfunction

  as_st_t            as_st_q, as_st_d;
  logic [2:0]        exp_q, exp_d;
  logic              commit_q, commit_d;
  logic [47:0]       asm_ts_q, asm_ts_d;
  smp_t              asm_smp_q, asm_smp_d;
  logic [1:0][47:0]  slot_ts_q, slot_ts_d;
  logic [1:0][7:0][15:0] slot_smp_q, slot_smp_d;
  logic [1:0]        slot_full_q, slot_full_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  em_st_t            em_st_q, em_st_d;
  logic              m_valid_q, m_valid_d;
  logic [31:0]       m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]       seq_err_cnt_q, seq_err_cnt_d;
  logic              overflow_q, overflow_d;

  logic [15:0]       s_ext;
  logic              accept;
  logic              free_now;
  logic [2:0]        nxt_idx;

  assign s_ext    = 16'(s_data);
  assign accept   = m_valid_q && m_ready;
  assign free_now = accept && (em_st_q == EM_W5);
  assign nxt_idx  = em_st_q + 3'd1;

  // Assembler: collects one frame in channel order; ch7 arms a commit for the next cycle
  always_comb begin
    as_st_d       = as_st_q;
    exp_d         = exp_q;
    commit_d      = 1'b0;
    asm_ts_d      = asm_ts_q;
    asm_smp_d     = asm_smp_q;
    seq_err_cnt_d = seq_err_cnt_q;
    case (as_st_q)
      AS_WAIT0: begin
        if (s_valid && s_chan == 3'd0) begin
          asm_ts_d     = s_time;
          asm_smp_d[0] = s_ext;
          exp_d        = 3'd1;
          as_st_d      = AS_COLLECT;
        end
      end
      AS_COLLECT: begin
        if (s_valid) begin
          if (s_chan == exp_q) begin
            asm_smp_d[s_chan] = s_ext;
            if (exp_q == 3'd7) begin
              commit_d = 1'b1;
              as_st_d  = AS_WAIT0;
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end else begin
            seq_err_cnt_d = sat_inc(seq_err_cnt_q);
            if (s_chan == 3'd0) begin
              asm_ts_d     = s_time;
              asm_smp_d[0] = s_ext;
              exp_d        = 3'd1;
            end else begin
              as_st_d = AS_WAIT0;
            end
          end
        end
      end
      default: as_st_d = AS_WAIT0;
    endcase
  end

  // Emitter and slot bookkeeping; the read slot is always the older of the two
  always_comb begin
    em_st_d     = em_st_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    slot_full_d = slot_full_q;
    slot_ts_d   = slot_ts_q;
    slot_smp_d  = slot_smp_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    case (em_st_q)
      EM_IDLE: begin
        if (slot_full_q[rd_ptr_q]) begin
          em_st_d   = EM_W0;
          m_valid_d = 1'b1;
          m_data_d  = frame_word(3'd0, slot_ts_q[rd_ptr_q], slot_smp_q[rd_ptr_q]);
          m_last_d  = 1'b0;
        end
      end
      EM_W0, EM_W1, EM_W2, EM_W3, EM_W4, EM_W5: begin
        if (accept) begin
          if (em_st_q == EM_W5) begin
            slot_full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d              = ~rd_ptr_q;
            frame_cnt_d           = frame_cnt_q + 16'd1;
            m_last_d              = 1'b0;
            if (slot_full_q[~rd_ptr_q]) begin
              em_st_d   = EM_W0;
              m_data_d  = frame_word(3'd0, slot_ts_q[~rd_ptr_q], slot_smp_q[~rd_ptr_q]);
            end else begin
              em_st_d   = EM_IDLE;
              m_valid_d = 1'b0;
            end
          end else begin
            em_st_d  = em_st_t'(nxt_idx);
            m_data_d = frame_word(nxt_idx, slot_ts_q[rd_ptr_q], slot_smp_q[rd_ptr_q]);
            m_last_d = (nxt_idx == 3'd5);
          end
        end
      end
      default: begin
        em_st_d   = EM_IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
      end
    endcase
    // A slot released by this cycle's final word is already free for the commit
    if (commit_q) begin
      if (slot_full_q[wr_ptr_q] && !(free_now && rd_ptr_q == wr_ptr_q)) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
        overflow_d = 1'b1;
      end else begin
        slot_ts_d[wr_ptr_q]   = asm_ts_q;
        slot_smp_d[wr_ptr_q]  = asm_smp_q;
        slot_full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d              = ~wr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      as_st_q       <= AS_WAIT0;
      exp_q         <= 3'd0;
      commit_q      <= 1'b0;
      slot_full_q   <= 2'b00;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      em_st_q       <= EM_IDLE;
      m_valid_q     <= 1'b0;
      m_data_q      <= 32'd0;
      m_last_q      <= 1'b0;
      frame_cnt_q   <= 16'd0;
      drop_cnt_q    <= 16'd0;
      seq_err_cnt_q <= 16'd0;
      overflow_q    <= 1'b0;
    end else begin
      as_st_q       <= as_st_d;
      exp_q         <= exp_d;
      commit_q      <= commit_d;
      slot_full_q   <= slot_full_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      em_st_q       <= em_st_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      seq_err_cnt_q <= seq_err_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_ts_q   <= asm_ts_d;
    asm_smp_q  <= asm_smp_d;
    slot_ts_q  <= slot_ts_d;
    slot_smp_q <= slot_smp_d;
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign seq_err_cnt = seq_err_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_xsm_frame_packer.sv
// Bench for xsm_frame_packer: a frame-level model predicts words and counters into a
// scoreboard; an independent monitor checks every word the DUT hands over.
module tb_xsm_frame_packer;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst, s_valid, m_ready, m_valid, m_last, overflow;
  logic [SW-1:0] s_data;
  logic [2:0]    s_chan;
  logic [47:0]   s_time;
  logic [31:0]   m_data;
  logic [15:0]   frame_cnt, drop_cnt, seq_err_cnt;

  always #5 clk = ~clk;

  xsm_frame_packer #(.SAMPLE_WIDTH(SW), .SYNC_WORD(16'hA55A)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_chan(s_chan),
    .s_time(s_time), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .seq_err_cnt(seq_err_cnt), .overflow(overflow)
  );

  int          n_vec = 0, n_miss = 0;
  logic [32:0] sb[$];
  int          occ = 0;
  int          n_acc = 0;
  int          rdy_mode = 0;
  logic [15:0] x_frames = 16'd0, x_drops = 16'd0, x_seq = 16'd0;
  logic        x_ovf = 1'b0;
  int          part_n = 0;
  logic [47:0] part_ts;
  logic [15:0] part_smp[8];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic frame_done();
    if (occ >= 2) begin
      x_drops = sat16(x_drops);
      x_ovf   = 1'b1;
    end else begin
      sb.push_back({1'b0, 16'hA55A, part_ts[47:32]});
      sb.push_back({1'b0, part_ts[31:0]});
      for (int p = 0; p < 4; p++) sb.push_back({p == 3, part_smp[2*p+1], part_smp[2*p]});
      occ++;
    end
  endtask

  task automatic model_sample(input logic [2:0] ch, input logic [15:0] d, input logic [47:0] t);
    if (part_n == 0) begin
      if (ch == 3'd0) begin part_ts = t; part_smp[0] = d; part_n = 1; end
    end else if (int'(ch) == part_n) begin
      part_smp[ch] = d;
      part_n++;
      if (part_n == 8) begin frame_done(); part_n = 0; end
    end else begin
      x_seq = sat16(x_seq);
      if (ch == 3'd0) begin part_ts = t; part_smp[0] = d; part_n = 1; end
      else part_n = 0;
    end
  endtask

  task automatic strobe(input logic [2:0] ch, input logic [15:0] d, input logic [47:0] t);
    @(posedge clk); #1;
    s_valid = 1'b1; s_chan = ch; s_data = d; s_time = t;
    model_sample(ch, d, t);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 16'($urandom); s_time = rnd48();
  endtask

  task automatic send_frame(input logic [47:0] ts, input logic fixed);
    for (int c = 0; c < 8; c++)
      strobe(3'(c), fixed ? 16'(16'h1000 + c) : 16'($urandom), (c == 0) ? ts : rnd48());
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, sb.size());
    end
  endtask

  task automatic wait_occ();
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk); #1;
      if (occ <= 1) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL occ_wait: got %0d frames buffered expected <=1", occ);
    end
  endtask

  task automatic chk_counters(input string name);
    chk({name, "_frame_cnt"}, 48'(frame_cnt), 48'(x_frames));
    chk({name, "_drop_cnt"}, 48'(drop_cnt), 48'(x_drops));
    chk({name, "_seq_err_cnt"}, 48'(seq_err_cnt), 48'(x_seq));
    chk({name, "_overflow"}, 48'(overflow), 48'(x_ovf));
  endtask

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b1;
  logic [31:0] pd = 32'd0;
  logic [32:0] e;
  always @(negedge clk) begin
    if (!rst && !prst && pv && !pr) begin
      chk("hold_valid", 48'(m_valid), 48'd1);
      chk("hold_data", 48'(m_data), 48'(pd));
      chk("hold_last", 48'(m_last), 48'(pl));
    end
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_word: got %08h expected none", m_data);
      end else begin
        e = sb.pop_front();
        chk("word", 48'(m_data), 48'(e[31:0]));
        chk("last", 48'(m_last), 48'(e[32]));
        n_acc++;
        if (e[32]) begin x_frames = x_frames + 16'd1; occ--; end
      end
    end
    pv = m_valid; pr = m_ready; pd = m_data; pl = m_last; prst = rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int base;
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_chan = 3'd0; s_time = 48'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 48'(m_valid), 48'd0);
    chk("rst_m_last", 48'(m_last), 48'd0);
    chk("rst_m_data", 48'(m_data), 48'd0);
    chk_counters("rst");

    // Known frame with full-rate ready
    rdy_mode = 1;
    send_frame(48'h0000_1234_5678, 1'b1);
    wait_drain("t1");
    chk_counters("t1");

    // Three frames with the sink stalled: two buffered, one dropped
    rdy_mode = 0;
    repeat (3) send_frame(rnd48(), 1'b0);
    repeat (6) @(negedge clk);
    chk_counters("t2_stalled");
    rdy_mode = 1;
    @(posedge clk); #2;
    repeat (12) begin
      @(negedge clk);
      chk("t2_no_bubble", 48'(m_valid), 48'd1);
    end
    wait_drain("t2");
    chk_counters("t2");

    // Channel-order violations and resync on ch0
    strobe(3'd0, 16'h0A00, rnd48());
    strobe(3'd1, 16'h0A01, rnd48());
    strobe(3'd2, 16'h0A02, rnd48());
    strobe(3'd5, 16'h0A05, rnd48());
    send_frame(rnd48(), 1'b0);
    strobe(3'd0, 16'h0B00, rnd48());
    strobe(3'd1, 16'h0B01, rnd48());
    send_frame(48'hBEEF_CAFE_0001, 1'b0);
    wait_drain("t3");
    chk_counters("t3");

    // Random ready with random sequence faults
    rdy_mode = 2;
    for (int b = 0; b < 40; b++) begin
      int ng, bad_k;
      logic [2:0] bad_c, ch;
      wait_occ();
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) strobe(3'($urandom_range(0, 7)), 16'($urandom), rnd48());
      bad_k = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      bad_c = 3'($urandom_range(0, 7));
      for (int c = 0; c < 8; c++) begin
        ch = 3'(c);
        if (bad_k != 0 && c == bad_k) ch = bad_c;
        strobe(ch, 16'($urandom), rnd48());
      end
    end
    wait_drain("t4");
    chk_counters("t4");

    // Reset while emitting word 3 with the other slot full
    rdy_mode = 0;
    send_frame(rnd48(), 1'b0);
    send_frame(rnd48(), 1'b0);
    base = n_acc;
    rdy_mode = 1;
    for (int i = 0; i < 200 && n_acc < base + 3; i++) @(posedge clk);
    rdy_mode = 0;
    chk("t5_accepted", 48'(n_acc - base), 48'd3);
    @(negedge clk);
    chk("t5_at_w3_valid", 48'(m_valid), 48'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    occ = 0; part_n = 0;
    x_frames = 16'd0; x_drops = 16'd0; x_seq = 16'd0; x_ovf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_m_valid", 48'(m_valid), 48'd0);
    chk("t5_m_last", 48'(m_last), 48'd0);
    chk_counters("t5_rst");
    rdy_mode = 1;
    repeat (6) @(negedge clk);
    chk("t5_slots_empty", 48'(m_valid), 48'd0);
    send_frame(rnd48(), 1'b0);
    wait_drain("t5");
    chk_counters("t5");

    // Back-to-back frames at minimum strobe spacing
    rdy_mode = 1;
    repeat (6) send_frame(rnd48(), 1'b0);
    wait_drain("t6");
    chk_counters("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
